// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit definitions: widths, state encoding, PC type.
package fetch_unit_pkg;

  localparam int DEF_PC_W  = 10;
  localparam int DEF_OFF_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    HALTED
  } fetch_state_t;

  typedef logic [DEF_PC_W-1:0] pc_t;

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC select for the RUN state: halt hold, jump, relative branch, step.
module fetch_unit_next_pc
  import fetch_unit_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int OFF_W = DEF_OFF_W
) (
  input  logic [PC_W-1:0]  pc,
  input  logic             halt,
  input  logic             jump_en,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             branch_en,
  input  logic [OFF_W-1:0] branch_off,
  output logic [PC_W-1:0]  npc
);

  // Add at the wider of the two widths, then keep the low PC_W bits.
  localparam int SW = (OFF_W > PC_W) ? OFF_W : PC_W;

  logic [SW-1:0] off_x;
  logic [SW-1:0] br_sum;

  assign off_x  = SW'($signed(branch_off));
  assign br_sum = SW'(pc) + off_x;

  always_comb begin
    npc = pc + PC_W'(1);
    priority case (1'b1)
      halt:      npc = pc;
      jump_en:   npc = jump_target;
      branch_en: npc = br_sum[PC_W-1:0];
      default:   npc = pc + PC_W'(1);
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// PC / fetch sequencer with start, halt and redirect handling.
// Optional retired-instruction counter: FETCH_INSTR_COUNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int OFF_W = DEF_OFF_W
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  input  logic             Halt,
  input  logic             jump_en,
  input  logic [PC_W-1:0]  JumpTarget,
  input  logic             branch_en,
  input  logic [OFF_W-1:0] BranchOff,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Fetch_valid,
  output logic             Done
`ifdef FETCH_INSTR_COUNT_EN
  ,
  output logic [31:0]      InstrCount
`endif
);

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc_q, pc_n;
  logic [PC_W-1:0] npc;
  logic [PC_W-1:0] start_addr_q;
  logic            start_d;
  logic            start_acc;
  logic            done_q, done_n;

  assign start_acc = Start & ~start_d;

  fetch_unit_next_pc #(
    .PC_W  (PC_W),
    .OFF_W (OFF_W)
  ) u_next_pc (
    .pc          (pc_q),
    .halt        (Halt),
    .jump_en     (jump_en),
    .jump_target (JumpTarget),
    .branch_en   (branch_en),
    .branch_off  (BranchOff),
    .npc         (npc)
  );

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      pc_q         <= '0;
      done_q       <= 1'b0;
      start_d      <= 1'b0;
      start_addr_q <= '0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      done_q  <= done_n;
      start_d <= Start;
      if (start_acc)
        start_addr_q <= StartAddr;
    end
  end

  // A start edge in RUN aborts the program ahead of any halt/redirect.
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    done_n  = done_q;
    unique case (state)
      IDLE: begin
        if (start_acc)
          state_n = LOAD;
      end
      LOAD: begin
        state_n = RUN;
        pc_n    = start_addr_q;
        done_n  = 1'b0;
      end
      RUN: begin
        if (start_acc) begin
          state_n = LOAD;
        end else if (Halt) begin
          state_n = HALTED;
          done_n  = 1'b1;
        end else begin
          pc_n = npc;
        end
      end
      HALTED: begin
        if (start_acc)
          state_n = LOAD;
      end
      default: state_n = IDLE;
    endcase
  end

  assign ProgCtr     = pc_q;
  assign Fetch_valid = (state == RUN);
  assign Done        = done_q;

`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)
      cnt_q <= '0;
    else if (state == LOAD)
      cnt_q <= '0;
    else if (state == RUN && cnt_q != '1)
      cnt_q <= cnt_q + 32'd1;
  end

  assign InstrCount = cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter / instruction-fetch unit.
- It consumes the jump_en and branch_en decisions produced by the control decoder, and drives the instruction ROM address.
- It owns start/halt sequencing of the core: it loads a start address on request, steps the PC each cycle, and redirects on jump/branch.
- It stops on a halt instruction and reports completion to the testbench/top level.

Parameters:
- PC_W, 10, program counter width in bits; ROM depth 2**PC_W.
- OFF_W, 8, width of signed branch offset.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  level request; a rising-edge-detected pulse begins or restarts a program.
- StartAddr  in  PC_W  first instruction address, sampled on the cycle Start is accepted.
- Halt  in  1  decoded halt instruction at current PC.
- jump_en  in  1  absolute redirect request from control decoder.
- JumpTarget  in  PC_W  absolute target (from jump LUT).
- branch_en  in  1  relative redirect request from control decoder.
- BranchOff  in  OFF_W  signed two's-complement branch offset.
- ProgCtr  out  PC_W  current PC, drives instruction ROM address.
- Fetch_valid  out  1  ProgCtr holds a live instruction this cycle (high only in RUN).
- Done  out  1  program finished; held until next accepted Start.

Behaviour:
- Reset: async on Reset_n low; state=IDLE, ProgCtr=0, Fetch_valid=0, Done=0, internal Start_d=0. Takes effect immediately, mid-program included; no PC update on the release edge unless Start rises.
- Start acceptance: registered Start_d; accept when Start=1 && Start_d=0 (rising edge). Level-held Start is accepted once.
- States (fetch_state_t):
  - IDLE: PC held. Accepted Start -> LOAD.
  - LOAD: one cycle. ProgCtr<=StartAddr (the value sampled at acceptance, registered), Done<=0 -> RUN.
  - RUN: Fetch_valid=1. Next-PC priority, evaluated each rising edge:
    1. Halt -> HALTED, PC held.
    2. jump_en -> PC<=JumpTarget.
    3. branch_en -> PC<=PC+sext(BranchOff).
    4. Otherwise PC<=PC+1.
  - HALTED: Done=1, Fetch_valid=0, PC frozen at the halt address. Accepted Start -> LOAD.
- Accepted Start in RUN aborts the program: -> LOAD, regardless of Halt/jump/branch that cycle.
- Arithmetic: all PC math is modulo 2**PC_W; wrap 2**PC_W-1 -> 0 on increment; negative offsets wrap below 0. BranchOff is sign-extended to PC_W before the add. If OFF_W > PC_W, the add is truncated to PC_W.
- jump_en, branch_en and Halt are ignored outside RUN.
- Simultaneous jump_en && branch_en: jump wins.
- Latency: a redirect decided in cycle n is visible on ProgCtr in cycle n+1. The first instruction appears 2 cycles after the Start edge: one cycle for acceptance, one for LOAD.

Optional Feature:
- Macro FETCH_INSTR_COUNT_EN.
- When defined:
  - Adds output InstrCount (32 bits).
  - Cleared on reset and in LOAD.
  - Increments each RUN cycle, the Halt cycle included; holds in IDLE and HALTED.
  - Saturates at 2**32-1.
- When undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- In the shared definitions package:
  - PC_W/OFF_W default constants.
  - typedef enum logic[1:0] fetch_state_t {IDLE, LOAD, RUN, HALTED}.
  - typedef logic[PC_W-1:0] pc_t.
- One natural sub-module: next_pc, a combinational priority mux plus sign-extend adder. The parent keeps the state register, Start edge detect and the PC register.

Test Plan:
- Start reset: Reset_n low mid-RUN with PC=0x05 -> ProgCtr=0, Fetch_valid=0, Done=0 immediately, without waiting for a clock edge.
- Sequential run and halt: StartAddr=0x10, pulse Start -> ProgCtr=0x10 two cycles later, then 0x11, 0x12. Halt at 0x12 -> Done=1, PC stays 0x12.
- Redirects: at PC=0x20, branch_en with BranchOff=0xFC -> 0x1C. At PC=0x20, jump_en with JumpTarget=0x300 and branch_en both high -> 0x300 (jump wins).
- Wrap: PC=0x3FF with no redirect -> 0x000. PC=0x001 with BranchOff=0x80 (-128) -> 0x381.
- Start behaviour: Start held high 5 cycles -> exactly one LOAD. New Start edge in HALTED with StartAddr=0x40 -> Done falls, PC=0x40. Start edge during RUN -> abort and reload.
- With FETCH_INSTR_COUNT_EN: run 0x10..0x14 with Halt at 0x14 -> InstrCount=5 at HALTED; a new Start clears it to 0 in LOAD.
